// File: rtl/tape_mem_arbiter_if.sv
// Bus bundle for the tape memory arbiter: interpreter core port, display scanner port, tape RAM port.
// The arbiter connects through the slave modport; requesters and the RAM use the master modport.
interface tape_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ack;
  logic [DATA_W-1:0] core_rdata;

  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_ack;
  logic [DATA_W-1:0] scan_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_ack, core_rdata,
    input  scan_req, scan_addr,
    output scan_ack, scan_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_ack, core_rdata,
    output scan_req, scan_addr,
    input  scan_ack, scan_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/tape_mem_arbiter.sv
// Two-requester arbiter (interpreter core over display scanner) for a single-port synchronous tape RAM.
// Define TAPE_ARB_STARVE_GUARD_EN to let the scanner through after STARVE_MAX contended core grants.
module tape_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input logic             clk,
  input logic             reset,
  tape_mem_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_range
    $error("tape_mem_arbiter: STARVE_MAX must be within 1..15");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic              owner_scan;
  logic              lat_we;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              core_ack_q;
  logic              scan_ack_q;
  logic              busy_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] scan_rdata_q;
  logic              grant_scan;

`ifdef TAPE_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign grant_scan = bus.scan_req && (!bus.core_req || starve_cnt == 4'(STARVE_MAX));

  // Counts core grants that were made while the scanner was waiting; only evaluated in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!bus.scan_req || grant_scan) begin
        starve_cnt <= '0;
      end else if (bus.core_req) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  assign grant_scan = bus.scan_req && !bus.core_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner_scan   <= 1'b0;
      lat_we       <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      core_ack_q   <= 1'b0;
      scan_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
      core_rdata_q <= '0;
      scan_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.core_req || bus.scan_req) begin
            state      <= ACCESS;
            busy_q     <= 1'b1;
            owner_scan <= grant_scan;
            if (grant_scan) begin
              mem_addr_q  <= bus.scan_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              lat_we      <= 1'b0;
            end else begin
              mem_addr_q  <= bus.core_addr;
              mem_we_q    <= bus.core_we;
              mem_wdata_q <= bus.core_wdata;
              lat_we      <= bus.core_we;
            end
          end
        end
        ACCESS: begin
          state      <= DONE;
          mem_we_q   <= 1'b0;
          core_ack_q <= !owner_scan;
          scan_ack_q <= owner_scan;
        end
        DONE: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          core_ack_q  <= 1'b0;
          scan_ack_q  <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          if (!lat_we) begin
            if (owner_scan) begin
              scan_rdata_q <= bus.mem_rdata;
            end else begin
              core_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM data arrives during DONE, so a read passes it straight through while ack is high.
  assign bus.core_rdata = (core_ack_q && !lat_we) ? bus.mem_rdata : core_rdata_q;
  assign bus.scan_rdata = (scan_ack_q && !lat_we) ? bus.mem_rdata : scan_rdata_q;
  assign bus.core_ack   = core_ack_q;
  assign bus.scan_ack   = scan_ack_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Bench for tape_mem_arbiter: vector table, corner-case sequences and random traffic against a
// transaction-level model with a shadow copy of the tape.
module tb_tape_mem_arbiter;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;
`ifdef TAPE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    bit         scan;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic ram_load = 1'b0;
  logic [7:0] ram [256];
  logic [7:0] shadow [256];
  logic [7:0] last_core, last_scan;
  int checks = 0;
  int errors = 0;
  vec_t vecs [10];

  tape_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  tape_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] initVal(input int i);
    logic [7:0] v;
    v = i[7:0];
    return v ^ 8'hA5;
  endfunction

  // Synchronous-read tape RAM, old data on a same-cycle write.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= initVal(i);
    end else begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.core_req = 1'b0;
    bus.scan_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    last_core = 8'h00;
    last_scan = 8'h00;
  endtask

  // One complete transaction with fixed timing: grant, ACCESS, DONE, back to IDLE.
  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.scan) begin
      bus.scan_req = 1'b1; bus.scan_addr = v.addr;
    end else begin
      bus.core_req = 1'b1; bus.core_we = v.we; bus.core_addr = v.addr; bus.core_wdata = v.wdata;
    end
    tick();
    checkOutput($sformatf("vec%0d_access", idx), {bus.busy, bus.mem_we, bus.core_ack, bus.scan_ack, bus.mem_addr},
                {1'b1, !v.scan && v.we, 1'b0, 1'b0, v.addr});
    if (!v.scan && v.we) checkOutput($sformatf("vec%0d_wdata", idx), bus.mem_wdata, v.wdata);
    tick();
    checkOutput($sformatf("vec%0d_ack", idx), {bus.busy, bus.mem_we, bus.core_ack, bus.scan_ack},
                {1'b1, 1'b0, !v.scan, v.scan});
    if (v.scan) begin
      checkOutput($sformatf("vec%0d_scan_rdata", idx), bus.scan_rdata, v.exp_rdata);
      checkOutput($sformatf("vec%0d_core_held", idx), bus.core_rdata, last_core);
      last_scan = v.exp_rdata;
      bus.scan_req = 1'b0;
    end else begin
      if (!v.we) begin
        checkOutput($sformatf("vec%0d_core_rdata", idx), bus.core_rdata, v.exp_rdata);
        last_core = v.exp_rdata;
      end else begin
        shadow[v.addr] = v.wdata;
      end
      checkOutput($sformatf("vec%0d_scan_held", idx), bus.scan_rdata, last_scan);
      bus.core_req = 1'b0;
    end
    tick();
    checkOutput($sformatf("vec%0d_idle", idx), {bus.busy, bus.mem_we, bus.core_ack, bus.scan_ack, bus.mem_addr, bus.mem_wdata},
                {4'b0000, 16'h0000});
  endtask

  // Random traffic from both requesters, checked every cycle against a transaction-level model.
  task automatic runRandom(input int ncyc);
    bit tx_on, tx_scan, tx_we, scan_win;
    logic [7:0] tx_addr, tx_wdata, tx_rd;
    int tx_grant, contended, cyc, age, c_gap, s_gap;
    tx_on = 0; contended = 0; cyc = 0;
    tx_scan = 0; tx_we = 0; tx_addr = 0; tx_wdata = 0; tx_rd = 0; tx_grant = 0;
    c_gap = $urandom_range(0, 3); s_gap = $urandom_range(0, 3);
    for (int n = 0; n < ncyc; n++) begin
      tick();
      cyc++;
      age = tx_on ? cyc - tx_grant : 99;
      checkOutput("rnd_ctl", {bus.busy, bus.mem_we, bus.core_ack, bus.scan_ack},
                  {age <= 1, age == 0 && !tx_scan && tx_we, age == 1 && !tx_scan, age == 1 && tx_scan});
      if (age == 0) checkOutput("rnd_addr", bus.mem_addr, tx_addr);
      if (age == 0 && !tx_scan && tx_we) checkOutput("rnd_wdata", bus.mem_wdata, tx_wdata);
      if (age >= 2) checkOutput("rnd_idle_bus", {bus.mem_addr, bus.mem_wdata}, 16'h0000);
      if (age == 1) begin
        if (tx_scan) begin
          checkOutput("rnd_scan_rdata", bus.scan_rdata, tx_rd);
          checkOutput("rnd_core_held", bus.core_rdata, last_core);
          last_scan = tx_rd;
          bus.scan_req = 1'b0;
          s_gap = $urandom_range(0, 3);
        end else begin
          if (!tx_we) begin
            checkOutput("rnd_core_rdata", bus.core_rdata, tx_rd);
            last_core = tx_rd;
          end
          checkOutput("rnd_scan_held", bus.scan_rdata, last_scan);
          bus.core_req = 1'b0;
          c_gap = $urandom_range(0, 3);
        end
      end
      if (!bus.core_req && n < ncyc - 12) begin
        if (c_gap == 0) begin
          bus.core_req = 1'b1; bus.core_we = 1'($urandom_range(0, 1));
          bus.core_addr = 8'($urandom_range(0, 15)); bus.core_wdata = 8'($urandom);
        end else c_gap--;
      end
      if (!bus.scan_req && n < ncyc - 12) begin
        if (s_gap == 0) begin
          bus.scan_req = 1'b1; bus.scan_addr = 8'($urandom_range(0, 15));
        end else s_gap--;
      end
      if (age >= 2) begin
        if (!bus.scan_req) contended = 0;
        if (bus.core_req || bus.scan_req) begin
          scan_win = bus.scan_req && (!bus.core_req || (GUARD && contended == STARVE_MAX));
          if (scan_win) contended = 0;
          else if (bus.scan_req) contended++;
          tx_on = 1; tx_grant = cyc + 1; tx_scan = scan_win;
          tx_we = !scan_win && bus.core_we;
          tx_addr = scan_win ? bus.scan_addr : bus.core_addr;
          tx_wdata = bus.core_wdata;
          tx_rd = shadow[tx_addr];
          if (tx_we) shadow[tx_addr] = tx_wdata;
        end
      end
    end
  endtask

  initial begin
    bit grants [$];
    int a, last_ack, n;
    reset = 1'b1;
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
    bus.scan_req = 0; bus.scan_addr = 0;
    for (int i = 0; i < 256; i++) shadow[i] = initVal(i);
    ram_load = 1'b1;
    tick();
    tick();
    ram_load = 1'b0;
    checkOutput("reset_outputs", {bus.busy, bus.mem_we, bus.core_ack, bus.scan_ack, bus.mem_addr, bus.mem_wdata,
                bus.core_rdata, bus.scan_rdata}, 36'h0);
    reset = 1'b0;
    last_core = 8'h00; last_scan = 8'h00;
    tick();
    checkOutput("post_reset_idle", {bus.busy, bus.core_ack, bus.scan_ack}, 3'b000);

    vecs[0] = '{scan: 0, we: 1, addr: 8'h05, wdata: 8'h2A, exp_rdata: 8'h00};
    vecs[1] = '{scan: 0, we: 0, addr: 8'h05, wdata: 8'h00, exp_rdata: 8'h2A};
    vecs[2] = '{scan: 1, we: 0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hB5};
    vecs[3] = '{scan: 0, we: 0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[4] = '{scan: 1, we: 0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[5] = '{scan: 0, we: 1, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h00};
    vecs[6] = '{scan: 1, we: 0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h00};
    vecs[7] = '{scan: 0, we: 0, addr: 8'h80, wdata: 8'h00, exp_rdata: 8'h25};
    vecs[8] = '{scan: 0, we: 1, addr: 8'h7F, wdata: 8'hC3, exp_rdata: 8'h00};
    vecs[9] = '{scan: 1, we: 0, addr: 8'h7F, wdata: 8'h00, exp_rdata: 8'hC3};
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Simultaneous requests: core first, scanner acked three cycles after the core.
    bus.core_req = 1; bus.core_we = 0; bus.core_addr = 8'h05;
    bus.scan_req = 1; bus.scan_addr = 8'h10;
    tick();
    checkOutput("both_first_addr", bus.mem_addr, 8'h05);
    tick();
    checkOutput("both_core_ack", {bus.core_ack, bus.scan_ack, bus.core_rdata}, {2'b10, 8'h2A});
    last_core = 8'h2A;
    bus.core_req = 0;
    n = 0;
    while (!bus.scan_ack && n < 8) begin tick(); n++; end
    checkOutput("both_scan_delay", n, 3);
    checkOutput("both_scan_rdata", bus.scan_rdata, 8'hB5);
    last_scan = 8'hB5;
    bus.scan_req = 0;
    tick();

    // Request withdrawn and altered during ACCESS of a read of 0x03.
    bus.core_req = 1; bus.core_we = 0; bus.core_addr = 8'h03;
    tick();
    bus.core_req = 0; bus.core_we = 1; bus.core_addr = 8'h44; bus.core_wdata = 8'hEE;
    tick();
    checkOutput("drop_core_ack", {bus.core_ack, bus.core_rdata}, {1'b1, shadow[3]});
    last_core = shadow[3];
    bus.core_we = 0;
    tick();
    checkOutput("drop_idle", {bus.busy, bus.core_ack}, 2'b00);

    runRandom(600);
    tick();

    // Scanner sweep of the whole tape at a three-cycle cadence.
    bus.scan_req = 1; bus.scan_addr = 8'h00;
    a = 0; last_ack = -1; n = 0;
    while (a < 256 && n < 800) begin
      tick();
      n++;
      if (bus.scan_ack) begin
        checkOutput("sweep_rdata", bus.scan_rdata, shadow[a]);
        if (last_ack >= 0) checkOutput("sweep_spacing", n - last_ack, 3);
        last_ack = n;
        a++;
        if (a < 256) bus.scan_addr = a[7:0];
        else bus.scan_req = 0;
      end
    end
    checkOutput("sweep_count", a, 256);
    checkOutput("sweep_core_held", bus.core_rdata, last_core);
    bus.scan_req = 0;
    tick();

    // Both requesters held high continuously.
    doReset();
    bus.core_req = 1; bus.core_we = 0; bus.core_addr = 8'h01;
    bus.scan_req = 1; bus.scan_addr = 8'h02;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.core_ack) grants.push_back(1'b0);
      if (bus.scan_ack) grants.push_back(1'b1);
    end
    checkOutput("starve_grant_count", grants.size(), 10);
    for (int g = 0; g < grants.size() && g < 10; g++)
      checkOutput($sformatf("starve_grant%0d", g), grants[g], GUARD && (g % (STARVE_MAX + 1)) == STARVE_MAX);
    bus.core_req = 0; bus.scan_req = 0;

    // Reset landing in ACCESS of a core write to 0x20.
    doReset();
    bus.core_req = 1; bus.core_we = 1; bus.core_addr = 8'h20; bus.core_wdata = 8'h77;
    tick();
    checkOutput("abort_access_we", bus.mem_we, 1'b1);
    reset = 1'b1;
    tick();
    checkOutput("abort_cleared", {bus.mem_we, bus.core_ack, bus.scan_ack, bus.busy, bus.mem_addr}, 12'h000);
    bus.core_req = 0;
    tick();
    checkOutput("abort_no_ack", {bus.core_ack, bus.mem_we}, 2'b00);
    reset = 1'b0;
    tick();
    checkOutput("abort_busy", {bus.busy, bus.core_ack}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
